// File: rtl/joystick_sampler_pkg.sv
// Shared types and defaults for the joystick sampler.
// Holds FSM encodings, sample bundle type and parameter defaults.
package joystick_sampler_pkg;

    localparam int ADC_W           = 10;
    localparam int PERIOD_CYC_DEF  = 50000;
    localparam int TIMEOUT_CYC_DEF = 256;
    localparam int AVG_SHIFT_DEF   = 2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_TRIG  = 3'd1,
        S_WAIT  = 3'd2,
        S_ACCUM = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    typedef struct packed {
        logic [ADC_W-1:0] x;
        logic [ADC_W-1:0] y;
    } sample_t;

    // Counter width for a modulus n, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/joystick_sampler_tick.sv
// Free-running period counter; emits a tick on its last count.
// Holds at zero while sampling is disabled.
module period_tick
    import joystick_sampler_pkg::*;
#(
    parameter int PERIOD_CYC = PERIOD_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam int CW = cnt_width(PERIOD_CYC);
    localparam logic [CW-1:0] LAST = CW'(PERIOD_CYC - 1);

    logic [CW-1:0] cnt_q;
    logic          at_last;

    assign at_last = (cnt_q == LAST);
    assign tick    = enable && at_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (!enable || at_last) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/joystick_sampler.sv
// Periodic two-channel ADC sampler with windowed averaging.
// Triggers the driver, waits with timeout, accumulates, publishes averages.
module joystick_sampler
    import joystick_sampler_pkg::*;
#(
    parameter int PERIOD_CYC  = PERIOD_CYC_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int AVG_SHIFT   = AVG_SHIFT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clear_err,
    output logic             adc_start,
    input  logic [ADC_W-1:0] adc_x,
    input  logic [ADC_W-1:0] adc_y,
    input  logic             adc_valid,
    output logic [ADC_W-1:0] x_avg,
    output logic [ADC_W-1:0] y_avg,
    output logic             avg_valid,
    output logic             busy,
    output logic             err_timeout,
    output logic             err_overrun
);

    localparam int AW = ADC_W + AVG_SHIFT;
    localparam int TW = cnt_width(TIMEOUT_CYC);
    localparam int SW = (AVG_SHIFT > 0) ? AVG_SHIFT : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [SW-1:0] WIN_LAST = SW'((1 << AVG_SHIFT) - 1);

    state_t        state_q, state_d;
    logic          tick;
    logic [TW-1:0] tmo_q;
    logic [SW-1:0] samp_q;
    logic [AW-1:0] acc_x_q, acc_y_q;
    logic [AW-1:0] sum_x, sum_y;
    sample_t       cap_q;

    logic tmo_last;
    logic win_done;
    logic to_evt;
    logic ov_evt;
    logic acc_clr;
    logic acc_add;
    logic avg_load;

    period_tick #(
        .PERIOD_CYC(PERIOD_CYC)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .enable(enable),
        .tick  (tick)
    );

    assign tmo_last = (tmo_q == TMO_LAST);
    assign win_done = (samp_q == WIN_LAST);
    assign sum_x    = acc_x_q + AW'(cap_q.x);
    assign sum_y    = acc_y_q + AW'(cap_q.y);

    always_comb begin
        state_d  = state_q;
        to_evt   = 1'b0;
        ov_evt   = tick && (state_q != S_IDLE);
        acc_clr  = 1'b0;
        acc_add  = 1'b0;
        avg_load = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                acc_clr = !enable;
                if (tick) state_d = S_TRIG;
            end
            S_TRIG: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (adc_valid) begin
                    state_d = S_ACCUM;
                end else if (tmo_last) begin
                    state_d = S_IDLE;
                    to_evt  = 1'b1;
                end
            end
            S_ACCUM: begin
                // A window finishing after disable is dropped, not published.
                acc_clr  = !enable || win_done;
                acc_add  = enable && !win_done;
                avg_load = enable && win_done;
                state_d  = avg_load ? S_OUT : S_IDLE;
            end
            S_OUT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q <= '0;
            cap_q <= '0;
        end else begin
            if (state_q == S_TRIG) begin
                tmo_q <= '0;
            end else if (state_q == S_WAIT) begin
                tmo_q <= tmo_q + TW'(1);
            end
            if (state_q == S_WAIT && adc_valid) begin
                cap_q.x <= adc_x;
                cap_q.y <= adc_y;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_x_q <= '0;
            acc_y_q <= '0;
            samp_q  <= '0;
        end else if (acc_clr) begin
            acc_x_q <= '0;
            acc_y_q <= '0;
            samp_q  <= '0;
        end else if (acc_add) begin
            acc_x_q <= sum_x;
            acc_y_q <= sum_y;
            samp_q  <= samp_q + SW'(1);
        end
    end

    // Outputs track the state being entered so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adc_start <= 1'b0;
            busy      <= 1'b0;
            avg_valid <= 1'b0;
            x_avg     <= '0;
            y_avg     <= '0;
        end else begin
            adc_start <= (state_d == S_TRIG);
            busy      <= (state_d != S_IDLE);
            avg_valid <= (state_d == S_OUT);
            if (avg_load) begin
                x_avg <= ADC_W'(sum_x >> AVG_SHIFT);
                y_avg <= ADC_W'(sum_y >> AVG_SHIFT);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            err_timeout <= to_evt || (err_timeout && !clear_err);
            err_overrun <= ov_evt || (err_overrun && !clear_err);
        end
    end

endmodule

// File: tb/tb_joystick_sampler.sv
// Directed bench: averaging window, timeout, overrun, disable, reset.
// A second instance with AVG_SHIFT=0 checks the pass-through case.
module tb_joystick_sampler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       clear_err = 1'b0;
    logic [9:0] adc_x = '0;
    logic [9:0] adc_y = '0;
    logic       adc_valid = 1'b0;

    logic       adc_start, avg_valid, busy, err_timeout, err_overrun;
    logic [9:0] x_avg, y_avg;
    logic       adc_start0, avg_valid0, busy0, err_timeout0, err_overrun0;
    logic [9:0] x_avg0, y_avg0;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    joystick_sampler #(
        .PERIOD_CYC(10), .TIMEOUT_CYC(16), .AVG_SHIFT(2)
    ) u_dut (
        .clk(clk), .rst(rst), .enable(enable), .clear_err(clear_err),
        .adc_start(adc_start), .adc_x(adc_x), .adc_y(adc_y),
        .adc_valid(adc_valid), .x_avg(x_avg), .y_avg(y_avg),
        .avg_valid(avg_valid), .busy(busy),
        .err_timeout(err_timeout), .err_overrun(err_overrun)
    );

    joystick_sampler #(
        .PERIOD_CYC(10), .TIMEOUT_CYC(16), .AVG_SHIFT(0)
    ) u_dut0 (
        .clk(clk), .rst(rst), .enable(enable), .clear_err(clear_err),
        .adc_start(adc_start0), .adc_x(adc_x), .adc_y(adc_y),
        .adc_valid(adc_valid), .x_avg(x_avg0), .y_avg(y_avg0),
        .avg_valid(avg_valid0), .busy(busy0),
        .err_timeout(err_timeout0), .err_overrun(err_overrun0)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] want);
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_start(input int budget);
        int n;
        n = 0;
        while (!adc_start && n < budget) begin
            step();
            n++;
        end
        chk("adc_start_seen", 32'(adc_start), 1);
    endtask

    // Entered in the TRIG cycle; answers after lat idle WAIT cycles and
    // returns two cycles after the strobe is sampled.
    task automatic conv(input int x, input int y, input int lat,
                        output int starts);
        starts = 0;
        step();
        if (adc_start) starts++;
        repeat (lat) begin
            step();
            if (adc_start) starts++;
        end
        adc_x = 10'(x);
        adc_y = 10'(y);
        adc_valid = 1'b1;
        step();
        if (adc_start) starts++;
        adc_valid = 1'b0;
        step();
        if (adc_start) starts++;
    endtask

    initial begin
        int xs[4];
        int ys[4];
        int t_prev, r, st, seen;

        xs = '{100, 200, 300, 401};
        ys = '{0, 0, 0, 1023};

        repeat (3) step();
        chk("rst_adc_start", 32'(adc_start), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_avg_valid", 32'(avg_valid), 0);
        chk("rst_x_avg", 32'(x_avg), 0);
        chk("rst_y_avg", 32'(y_avg), 0);
        chk("rst_err_timeout", 32'(err_timeout), 0);
        chk("rst_err_overrun", 32'(err_overrun), 0);

        rst = 1'b0;
        enable = 1'b1;
        r = cyc;
        t_prev = 0;
        for (int k = 0; k < 4; k++) begin
            wait_start(30);
            if (k == 0) chk("first_trig_delay", 32'(cyc - r), 10);
            else chk("trig_spacing", 32'(cyc - t_prev), 10);
            t_prev = cyc;
            conv(xs[k], ys[k], 2, st);
            chk("extra_start", 32'(st), 0);
            chk("win_avg_valid", 32'(avg_valid), (k == 3) ? 1 : 0);
            chk("win_busy", 32'(busy), (k == 3) ? 1 : 0);
            chk("s0_avg_valid", 32'(avg_valid0), 1);
            chk("s0_x_avg", 32'(x_avg0), 32'(xs[k]));
            chk("s0_y_avg", 32'(y_avg0), 32'(ys[k]));
        end
        chk("win_x_avg", 32'(x_avg), 250);
        chk("win_y_avg", 32'(y_avg), 255);
        step();
        chk("avg_valid_one_cycle", 32'(avg_valid), 0);
        chk("x_avg_hold", 32'(x_avg), 250);

        wait_start(30);
        chk("tmo_trig_spacing", 32'(cyc - t_prev), 10);
        t_prev = cyc;
        seen = 0;
        repeat (16) begin
            step();
            if (avg_valid) seen++;
        end
        chk("tmo_busy_before", 32'(busy), 1);
        chk("tmo_err_before", 32'(err_timeout), 0);
        step();
        chk("tmo_err_set", 32'(err_timeout), 1);
        chk("tmo_idle", 32'(busy), 0);
        chk("tmo_overrun_too", 32'(err_overrun), 1);
        chk("tmo_no_avg", 32'(seen + 32'(avg_valid)), 0);
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        chk("clr_err_timeout", 32'(err_timeout), 0);
        chk("clr_err_overrun", 32'(err_overrun), 0);

        wait_start(30);
        chk("tmo2_trig_spacing", 32'(cyc - t_prev), 20);
        t_prev = cyc;
        repeat (16) step();
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        chk("set_wins_timeout", 32'(err_timeout), 1);
        chk("clear_overrun", 32'(err_overrun), 0);
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        chk("clear_after_set", 32'(err_timeout), 0);

        wait_start(30);
        chk("ovr_trig_spacing", 32'(cyc - t_prev), 20);
        t_prev = cyc;
        conv(1000, 1000, 14, st);
        chk("ovr_single_start", 32'(st), 0);
        chk("ovr_err_set", 32'(err_overrun), 1);
        chk("ovr_no_timeout", 32'(err_timeout), 0);
        chk("ovr_no_avg", 32'(avg_valid), 0);
        chk("ovr_s0_x_avg", 32'(x_avg0), 1000);
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        chk("ovr_err_clear", 32'(err_overrun), 0);

        wait_start(30);
        chk("ovr_resume_spacing", 32'(cyc - t_prev), 20);
        conv(1000, 1000, 2, st);
        chk("part_no_avg", 32'(avg_valid), 0);
        enable = 1'b0;
        seen = 0;
        repeat (15) begin
            step();
            if (adc_start || avg_valid || busy) seen++;
        end
        chk("disabled_quiet", 32'(seen), 0);

        enable = 1'b1;
        t_prev = cyc;
        for (int k = 0; k < 4; k++) begin
            wait_start(30);
            chk("reen_spacing", 32'(cyc - t_prev), 10);
            t_prev = cyc;
            conv(512, 512, 2, st);
            chk("reen_avg_valid", 32'(avg_valid), (k == 3) ? 1 : 0);
        end
        chk("reen_x_avg", 32'(x_avg), 512);
        chk("reen_y_avg", 32'(y_avg), 512);

        wait_start(30);
        chk("pre_rst_spacing", 32'(cyc - t_prev), 10);
        step();
        step();
        chk("wait_busy", 32'(busy), 1);
        rst = 1'b1;
        #1;
        chk("async_rst_busy", 32'(busy), 0);
        chk("async_rst_x_avg", 32'(x_avg), 0);
        repeat (3) step();
        chk("rst_hold_start", 32'(adc_start), 0);
        chk("rst_hold_avg", 32'(avg_valid), 0);
        chk("rst_hold_y_avg", 32'(y_avg), 0);
        rst = 1'b0;
        r = cyc;
        adc_x = 10'd77;
        adc_y = 10'd77;
        adc_valid = 1'b1;
        step();
        adc_valid = 1'b0;
        chk("late_valid_busy", 32'(busy), 0);
        wait_start(30);
        chk("post_rst_trig_delay", 32'(cyc - r), 10);
        chk("late_valid_ignored", 32'(x_avg), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
